// File: rtl/link_sprite_fetch_if.sv
// Signal bundle between the scan/sprite-state side, the sprite index ROM and the fetch stage.
// The master side drives scan position, sprite state and ROM data; the slave is the fetch stage.
interface link_sprite_fetch_if #(
    parameter int SPRITE_W = 16
);
    localparam int ADDR_W = 3 + 2 * $clog2(SPRITE_W);

    logic              frame_start;
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic [9:0]        LinkX;
    logic [9:0]        LinkY;
    logic [1:0]        dir;
    logic              moving;
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        rom_data;
    logic [3:0]        pix_index;
    logic              pix_hit;

    modport master (
        output frame_start, DrawX, DrawY, LinkX, LinkY, dir, moving, rom_data,
        input  rom_addr, pix_index, pix_hit
    );

    modport slave (
        input  frame_start, DrawX, DrawY, LinkX, LinkY, dir, moving, rom_data,
        output rom_addr, pix_index, pix_hit
    );
endinterface

// File: rtl/link_sprite_fetch.sv
// Player sprite per-pixel fetch: box test, texel addressing into a synchronous index ROM,
// and a fixed 2-cycle pipeline delivering palette index plus hit flag.
module link_sprite_fetch #(
    parameter int SPRITE_W = 16,
    parameter int SCALE    = 2,
    parameter int ANIM_DIV = 8
) (
    input logic                Clk,
    input logic                Reset,
    link_sprite_fetch_if.slave bus
);
    localparam int COL_W  = $clog2(SPRITE_W);
    localparam int SC_W   = $clog2(SCALE);
    localparam int CNT_W  = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int ADDR_W = 3 + 2 * COL_W;

    localparam logic [10:0]      BOX_SPAN = 11'(SPRITE_W * SCALE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_DIV - 1);

    logic [9:0]        r_x_l;
    logic [9:0]        r_y_l;
    logic [1:0]        r_dir_l;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_anim;

    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_in_box_d1;
    logic              r_in_box_d2;
    logic [3:0]        r_pix_index;
    logic              r_pix_hit;

    logic [10:0]       w_draw_x;
    logic [10:0]       w_draw_y;
    logic [10:0]       w_x_l;
    logic [10:0]       w_y_l;
    logic [10:0]       w_dx;
    logic [10:0]       w_dy;
    logic [COL_W-1:0]  w_col;
    logic [COL_W-1:0]  w_row;
    logic              w_in_box;
    logic [ADDR_W-1:0] w_addr;

    // Sprite position/direction and walk animation only change at frame start, so no tearing.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_x_l   <= '0;
            r_y_l   <= '0;
            r_dir_l <= '0;
            r_cnt   <= '0;
            r_anim  <= 1'b0;
        end else if (bus.frame_start) begin
            r_x_l   <= bus.LinkX;
            r_y_l   <= bus.LinkY;
            r_dir_l <= bus.dir;
            if (bus.moving) begin
                if (r_cnt == CNT_LAST) begin
                    r_cnt  <= '0;
                    r_anim <= ~r_anim;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt  <= '0;
                r_anim <= 1'b0;
            end
        end
    end

    // 11-bit arithmetic keeps the box end from wrapping near the right screen edge.
    assign w_draw_x = {1'b0, bus.DrawX};
    assign w_draw_y = {1'b0, bus.DrawY};
    assign w_x_l    = {1'b0, r_x_l};
    assign w_y_l    = {1'b0, r_y_l};
    assign w_dx     = w_draw_x - w_x_l;
    assign w_dy     = w_draw_y - w_y_l;
    assign w_col    = COL_W'(w_dx >> SC_W);
    assign w_row    = COL_W'(w_dy >> SC_W);

    assign w_in_box = (w_draw_x >= w_x_l) && (w_draw_x < w_x_l + BOX_SPAN) &&
                      (w_draw_y >= w_y_l) && (w_draw_y < w_y_l + BOX_SPAN);

    assign w_addr   = {r_dir_l, r_anim, w_row, w_col};

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_rom_addr  <= '0;
            r_in_box_d1 <= 1'b0;
            r_in_box_d2 <= 1'b0;
            r_pix_index <= '0;
            r_pix_hit   <= 1'b0;
        end else begin
            r_rom_addr  <= w_in_box ? w_addr : '0;
            r_in_box_d1 <= w_in_box;
            r_in_box_d2 <= r_in_box_d1;
            r_pix_index <= r_in_box_d2 ? bus.rom_data : 4'd0;
            r_pix_hit   <= r_in_box_d2 && (bus.rom_data != 4'd0);
        end
    end

    assign bus.rom_addr  = r_rom_addr;
    assign bus.pix_index = r_pix_index;
    assign bus.pix_hit   = r_pix_hit;
endmodule

// File: tb/tb_link_sprite_fetch.sv
// Directed bench for link_sprite_fetch with a bench-side synchronous sprite ROM.
module tb_link_sprite_fetch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    link_sprite_fetch_if #(.SPRITE_W(16)) bus ();

    link_sprite_fetch #(.SPRITE_W(16), .SCALE(2), .ANIM_DIV(8)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    logic [3:0] mem [0:2047];
    always @(posedge clk) bus.rom_data <= mem[bus.rom_addr];

    int checks = 0;
    int errors = 0;
    logic [10:0] got_addr;
    logic [3:0]  got_idx;
    logic        got_hit;

    function automatic logic box(input int x, input int y, input int lx, input int ly);
        return (x >= lx) && (x < lx + 32) && (y >= ly) && (y < ly + 32);
    endfunction

    function automatic logic [10:0] exp_addr(input int x, input int y, input int lx, input int ly,
                                             input int d, input int a);
        if (box(x, y, lx, ly))
            return {2'(d), 1'(a), 4'((y - ly) / 2), 4'((x - lx) / 2)};
        return 11'd0;
    endfunction

    // Entered at a negedge; returns with the address after the sampling edge and the pixel after 2 more.
    task automatic pixel(input int x, input int y);
        bus.DrawX = 10'(x);
        bus.DrawY = 10'(y);
        @(negedge clk);
        got_addr = bus.rom_addr;
        @(negedge clk);
        @(negedge clk);
        got_idx = bus.pix_index;
        got_hit = bus.pix_hit;
    endtask

    task automatic frame(input int lx, input int ly, input int d, input int mv);
        bus.LinkX       = 10'(lx);
        bus.LinkY       = 10'(ly);
        bus.dir         = 2'(d);
        bus.moving      = mv[0];
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
    endtask

    task automatic test_reset();
        checks += 3;
        if (bus.rom_addr !== 11'd0) begin errors++; $display("FAIL reset_addr: got %h expected 000", bus.rom_addr); end
        if (bus.pix_index !== 4'd0) begin errors++; $display("FAIL reset_idx: got %h expected 0", bus.pix_index); end
        if (bus.pix_hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b expected 0", bus.pix_hit); end
        rst = 1'b0;
        pixel(0, 0);
        checks += 3;
        if (got_addr !== 11'h000) begin errors++; $display("FAIL post_reset_addr: got %h expected 000", got_addr); end
        if (got_idx !== 4'd3) begin errors++; $display("FAIL post_reset_idx: got %h expected 3", got_idx); end
        if (got_hit !== 1'b1) begin errors++; $display("FAIL post_reset_hit: got %b expected 1", got_hit); end
    endtask

    task automatic test_basic_hit();
        frame(100, 50, 1, 0);
        pixel(100, 50);
        checks += 3;
        if (got_addr !== 11'h200) begin errors++; $display("FAIL basic_addr: got %h expected 200", got_addr); end
        if (got_idx !== 4'd5) begin errors++; $display("FAIL basic_idx: got %h expected 5", got_idx); end
        if (got_hit !== 1'b1) begin errors++; $display("FAIL basic_hit: got %b expected 1", got_hit); end
        pixel(101, 50);
        checks += 2;
        if (got_addr !== 11'h200) begin errors++; $display("FAIL same_texel_addr: got %h expected 200", got_addr); end
        if (got_idx !== 4'd5) begin errors++; $display("FAIL same_texel_idx: got %h expected 5", got_idx); end
        pixel(131, 81);
        checks += 2;
        if (got_addr !== 11'h2FF) begin errors++; $display("FAIL corner_addr: got %h expected 2ff", got_addr); end
        if (got_idx !== 4'd5) begin errors++; $display("FAIL corner_idx: got %h expected 5", got_idx); end
        pixel(132, 50);
        checks += 3;
        if (got_addr !== 11'h000) begin errors++; $display("FAIL right_out_addr: got %h expected 000", got_addr); end
        if (got_idx !== 4'd0) begin errors++; $display("FAIL right_out_idx: got %h expected 0", got_idx); end
        if (got_hit !== 1'b0) begin errors++; $display("FAIL right_out_hit: got %b expected 0", got_hit); end
        pixel(100, 82);
        checks += 1;
        if (got_hit !== 1'b0) begin errors++; $display("FAIL bottom_out_hit: got %b expected 0", got_hit); end
    endtask

    task automatic test_transparency();
        pixel(104, 56);
        checks += 3;
        if (got_addr !== 11'h232) begin errors++; $display("FAIL transp_addr: got %h expected 232", got_addr); end
        if (got_idx !== 4'd0) begin errors++; $display("FAIL transp_idx: got %h expected 0", got_idx); end
        if (got_hit !== 1'b0) begin errors++; $display("FAIL transp_hit: got %b expected 0", got_hit); end
    endtask

    task automatic test_mid_frame_latch();
        bus.LinkX = 10'd200;
        pixel(100, 50);
        checks += 2;
        if (got_addr !== 11'h200) begin errors++; $display("FAIL held_latch_addr: got %h expected 200", got_addr); end
        if (got_hit !== 1'b1) begin errors++; $display("FAIL held_latch_hit: got %b expected 1", got_hit); end
        pixel(200, 50);
        checks += 1;
        if (got_hit !== 1'b0) begin errors++; $display("FAIL early_move_hit: got %b expected 0", got_hit); end
        frame(200, 50, 1, 0);
        pixel(200, 50);
        checks += 2;
        if (got_addr !== 11'h200) begin errors++; $display("FAIL moved_addr: got %h expected 200", got_addr); end
        if (got_hit !== 1'b1) begin errors++; $display("FAIL moved_hit: got %b expected 1", got_hit); end
        pixel(100, 50);
        checks += 1;
        if (got_hit !== 1'b0) begin errors++; $display("FAIL old_pos_hit: got %b expected 0", got_hit); end
    endtask

    task automatic test_coincident_frame_start();
        frame(100, 50, 1, 0);
        bus.DrawX       = 10'd100;
        bus.DrawY       = 10'd50;
        bus.LinkX       = 10'd300;
        bus.dir         = 2'd2;
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        checks += 1;
        if (bus.rom_addr !== 11'h200) begin errors++; $display("FAIL coinc_old_addr: got %h expected 200", bus.rom_addr); end
        @(negedge clk);
        checks += 1;
        if (bus.rom_addr !== 11'h000) begin errors++; $display("FAIL coinc_next_addr: got %h expected 000", bus.rom_addr); end
        pixel(300, 50);
        checks += 1;
        if (got_addr !== 11'h400) begin errors++; $display("FAIL coinc_new_addr: got %h expected 400", got_addr); end
    endtask

    task automatic test_right_edge();
        int xs[34];
        int ys[34];
        logic [10:0] ea;
        logic [3:0]  ei;
        logic        eh;
        for (int i = 0; i < 22; i++) begin xs[i] = 618 + i; ys[i] = 200; end
        for (int i = 0; i < 12; i++) begin xs[22 + i] = i; ys[22 + i] = 201; end
        frame(620, 200, 3, 0);
        for (int j = 0; j < 37; j++) begin
            if (j >= 1) begin
                ea = exp_addr(xs[j-1], ys[j-1], 620, 200, 3, 0);
                checks++;
                if (bus.rom_addr !== ea) begin
                    errors++;
                    $display("FAIL edge_addr x=%0d y=%0d: got %h expected %h", xs[j-1], ys[j-1], bus.rom_addr, ea);
                end
            end
            if (j >= 3) begin
                eh = (ys[j-3] == 200) && (xs[j-3] >= 620);
                ea = exp_addr(xs[j-3], ys[j-3], 620, 200, 3, 0);
                ei = eh ? mem[ea] : 4'd0;
                eh = eh && (ei != 4'd0);
                checks += 2;
                if (bus.pix_hit !== eh) begin
                    errors++;
                    $display("FAIL edge_hit x=%0d y=%0d: got %b expected %b", xs[j-3], ys[j-3], bus.pix_hit, eh);
                end
                if (bus.pix_index !== ei) begin
                    errors++;
                    $display("FAIL edge_idx x=%0d y=%0d: got %h expected %h", xs[j-3], ys[j-3], bus.pix_index, ei);
                end
            end
            if (j < 34) begin
                bus.DrawX = 10'(xs[j]);
                bus.DrawY = 10'(ys[j]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_anim();
        logic [10:0] ea;
        for (int p = 1; p <= 8; p++) begin
            frame(0, 0, 0, 1);
            pixel(0, 0);
            ea = (p == 8) ? 11'h100 : 11'h000;
            checks++;
            if (got_addr !== ea) begin errors++; $display("FAIL anim_run pulse=%0d: got %h expected %h", p, got_addr, ea); end
        end
        for (int p = 0; p < 5; p++) frame(0, 0, 0, 1);
        pixel(0, 0);
        checks++;
        if (got_addr !== 11'h100) begin errors++; $display("FAIL anim_hold: got %h expected 100", got_addr); end
        frame(0, 0, 0, 0);
        pixel(0, 0);
        checks++;
        if (got_addr !== 11'h000) begin errors++; $display("FAIL anim_stop: got %h expected 000", got_addr); end
        for (int p = 1; p <= 8; p++) begin
            frame(0, 0, 0, 1);
            if (p >= 7) begin
                pixel(0, 0);
                ea = (p == 8) ? 11'h100 : 11'h000;
                checks++;
                if (got_addr !== ea) begin errors++; $display("FAIL anim_restart pulse=%0d: got %h expected %h", p, got_addr, ea); end
            end
        end
    endtask

    task automatic test_async_reset();
        frame(100, 50, 1, 1);
        pixel(100, 50);
        checks += 3;
        if (got_addr !== 11'h300) begin errors++; $display("FAIL pre_rst_addr: got %h expected 300", got_addr); end
        if (got_idx !== 4'd6) begin errors++; $display("FAIL pre_rst_idx: got %h expected 6", got_idx); end
        if (got_hit !== 1'b1) begin errors++; $display("FAIL pre_rst_hit: got %b expected 1", got_hit); end
        #2 rst = 1'b1;
        #1;
        checks += 3;
        if (bus.pix_hit !== 1'b0) begin errors++; $display("FAIL async_hit: got %b expected 0", bus.pix_hit); end
        if (bus.pix_index !== 4'd0) begin errors++; $display("FAIL async_idx: got %h expected 0", bus.pix_index); end
        if (bus.rom_addr !== 11'd0) begin errors++; $display("FAIL async_addr: got %h expected 000", bus.rom_addr); end
        bus.DrawX = 10'd0;
        bus.DrawY = 10'd0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.pix_hit !== 1'b0) begin errors++; $display("FAIL early_hit_after_rst: got %b expected 0", bus.pix_hit); end
        @(negedge clk);
        @(negedge clk);
        checks += 3;
        if (bus.rom_addr !== 11'h000) begin errors++; $display("FAIL cleared_state_addr: got %h expected 000", bus.rom_addr); end
        if (bus.pix_hit !== 1'b1) begin errors++; $display("FAIL cleared_latch_hit: got %b expected 1", bus.pix_hit); end
        if (bus.pix_index !== 4'd3) begin errors++; $display("FAIL cleared_latch_idx: got %h expected 3", bus.pix_index); end
        pixel(100, 50);
        checks++;
        if (got_hit !== 1'b0) begin errors++; $display("FAIL old_latch_after_rst: got %b expected 0", got_hit); end
    endtask

    initial begin
        logic [10:0] av;
        for (int a = 0; a < 2048; a++) begin
            av = 11'(a);
            mem[a] = (av[3:0] ^ av[7:4]) + {1'b0, av[10:8]} + 4'd3;
        end
        mem[11'h232] = 4'd0;
        bus.frame_start = 1'b0;
        bus.DrawX  = '0;
        bus.DrawY  = '0;
        bus.LinkX  = '0;
        bus.LinkY  = '0;
        bus.dir    = '0;
        bus.moving = 1'b0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_basic_hit();
        test_transparency();
        test_mid_frame_latch();
        test_coincident_frame_start();
        test_right_edge();
        test_anim();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/link_sprite_fetch.md
# link_sprite_fetch

Per-pixel fetch stage for the player sprite. Sits between the VGA scan counters and the sprite palette lookup. From the current scan position and the sprite's latched position, direction and animation state, it addresses a synchronous sprite index ROM and delivers a 4-bit palette index with a hit flag, aligned to a fixed 2-cycle pipeline. Downstream, the index drives the sprite palette (index to 12-bit RGB), and the hit flag drives the background/sprite mux.

## Interface
Parameters:
- SPRITE_W, 16, sprite side length in ROM texels (power of two)
- SCALE, 2, on-screen pixels per texel per axis (power of two)
- ANIM_DIV, 8, frame_start pulses per walk-animation step (≥1)

Ports:
- Clk  in  1  pixel clock; all state on rising edge
- Reset  in  1  asynchronous, active-high; clears all state immediately
- frame_start  in  1  one-cycle pulse at start of vertical blank
- DrawX  in  10  current scan column, 0–639
- DrawY  in  10  current scan row, 0–479
- LinkX  in  10  sprite top-left column (screen pixels)
- LinkY  in  10  sprite top-left row
- dir  in  2  facing: 0 up, 1 down, 2 left, 3 right
- moving  in  1  high while the player is walking
- rom_addr  out  11  {dir_l[1:0], anim, row[3:0], col[3:0]} for SPRITE_W=16
- rom_data  in  4  ROM output, valid one cycle after rom_addr is registered
- pix_index  out  4  palette index for the pixel presented 2 cycles earlier
- pix_hit  out  1  pixel is inside the sprite box and index ≠ 0 (0 = transparent)

## Operation
- Frame latch: on frame_start, register LinkX, LinkY and dir into X_l, Y_l and dir_l. All addressing within the frame uses only the latched values, so the sprite never tears mid-frame.
- Animation counter cnt (width clog2(ANIM_DIV)), bit anim:
  - On frame_start with moving=1: if cnt == ANIM_DIV−1, then cnt←0 and anim←~anim. Otherwise cnt←cnt+1.
  - On frame_start with moving=0: cnt←0 and anim←0.
  - Without frame_start: hold.
  - ANIM_DIV=1 toggles anim on every moving frame_start.
- Box test (stage 1 comb): zero-extend all coordinates to 11 bits. dx = DrawX − X_l and dy = DrawY − Y_l, both 11-bit.
  - in_box = (DrawX ≥ X_l) && (DrawX < X_l + SPRITE_W·SCALE) && (DrawY ≥ Y_l) && (DrawY < Y_l + SPRITE_W·SCALE).
  - The 11-bit sum must not wrap: X_l=630 still covers 630–661, and DrawX never reaches 640, so there is no false hit.
- Texel: col = dx >> log2(SCALE), row = dy >> log2(SCALE), each log2(SPRITE_W) bits.
- Stage 1 register: rom_addr ← in_box ? {dir_l, anim, row, col} : 0. Also in_box_d1 ← in_box.
- Stage 2 register: pix_index ← in_box_d2 ? rom_data : 0, where in_box_d2 is in_box_d1 delayed by one cycle. pix_hit ← in_box_d2 && (rom_data ≠ 0).
- frame_start coinciding with an active pixel: the new latch values apply from the next cycle's address computation. The pixel presented in the same cycle uses the old values.

## Timing
- Reset values: rom_addr=0, pix_index=0, pix_hit=0, X_l=Y_l=0, dir_l=0, cnt=0, anim=0, all pipeline flags 0.
- Latency: DrawX/DrawY sampled at edge t. rom_addr is valid after t. rom_data is valid after t+1. pix_index/pix_hit are valid after t+2.
- Throughput: one pixel per clock, with no stalls and no handshake.
- Reset asserted mid-line: outputs go to 0 asynchronously. After deassertion, the first valid pix_hit appears no earlier than 2 edges later. The sprite stays at X_l=Y_l=0 until the next frame_start.
- Reset has priority over frame_start.

## Test plan
- Basic hit, SCALE=2: after frame_start with LinkX=100, LinkY=50, dir=1 and ROM texel (0,0) of frame {1,0} = 5, present DrawX=100, DrawY=50 at t. Required: rom_addr=0x200 after t, pix_index=5 and pix_hit=1 after t+2. DrawX=101 maps to the same texel. DrawX=132 gives pix_hit=0 and pix_index=0.
- Transparency: a texel with rom_data=0 inside the box -> pix_index=0 and pix_hit=0.
- Right-edge box: LinkX=620, scan DrawX 618–639 on row LinkY. Required: pix_hit only for 620–639, and no hit on DrawX 0–11 of the next line.
- Mid-frame latch: change LinkX from 100 to 200 without frame_start. Required: hits stay at 100–131 until after the next frame_start.
- Animation, ANIM_DIV=8: with moving=1, anim toggles on the 8th, 16th, … frame_start. Drop moving after 5 pulses: anim=0 and cnt=0 on the next frame_start.
- Async reset mid-scan with pix_hit=1: pix_hit and pix_index go to 0 before the next edge. rom_addr=0, and anim and latches are cleared.
